// File: rtl/noc_pkg.sv
// Shared constants for the mesh router.
// Holds the default flit width and requester count, the VC numbering
// (VC_EVEN/VC_ODD) and the router's output direction indices.
package noc_pkg;

    // Default flit width in bits and default number of requesting inputs.
    localparam int DEF_DATA_W = 64;
    localparam int DEF_NREQ   = 4;

    // Virtual-channel numbering; the router polarity names the internal VC.
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // Output direction indices, one output_port_scheduler per direction.
    localparam int DIR_E  = 0;
    localparam int DIR_W  = 1;
    localparam int DIR_N  = 2;
    localparam int DIR_S  = 3;
    localparam int DIR_PE = 4;

endpackage

// File: rtl/rr_grant_core.sv
// Round-robin grant core.
// Holds the last-winner pointer and searches upward from pointer+1 with
// wrap-around for the first active request.
// Ports:
//   clk, reset   - clock and synchronous active-low reset
//   req          - request vector
//   enable       - allows the pointer to advance (it moves only if |req too)
//   grant        - one-hot combinational grant (all zero when no request)
//   winner       - index of the granted requester
module rr_grant_core
    import noc_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Rotating priority search: the candidate after the last winner is
    // checked first, so the last winner comes up for grant only after
    // every other requester has been passed over.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and no latch is inferred.
        grant  = '0;
        winner = ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner       = cand;
                grant[cand]  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (enable && (|req)) begin
            ptr_d = winner;
        end
    end

    // Reset to the last index so input 0 has first priority.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before the edge.
        if (!reset) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Per-output-port scheduler.
// Arbitrates round-robin among NREQ inputs and stores the winner in a two-slot
// VC buffer. It also handles the send/ready handshake downstream.
// Ports:
//   clk, reset - clock and synchronous active-low reset
//   polarity   - router polarity; slot[polarity] is internal (fillable),
//                slot[~polarity] is external (drainable)
//   req        - per-input request for this port on VC = polarity
//   data_in    - packed input flits, input i at [i*DATA_W +: DATA_W]
//   clear      - registered one-hot pulse to the input whose flit was taken
//   empty      - per-VC slot-empty flags
//   ro         - downstream ready for the external VC
//   so         - registered send-valid pulse, one per flit
//   data_out   - flit to downstream, valid while so=1
module output_port_scheduler
    import noc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREQ   = DEF_NREQ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data_in,
    output logic [NREQ-1:0]        clear,
    output logic [1:0]             empty,
    input  logic                   ro,
    output logic                   so,
    output logic [DATA_W-1:0]      data_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              int_vc, ext_vc;
    logic              fill, drain;
    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  winner;

    logic [1:0]        full_q, full_d;
    logic [DATA_W-1:0] slot_q [2];
    logic [DATA_W-1:0] slot_d [2];
    logic [NREQ-1:0]   clear_q, clear_d;
    logic              so_q, so_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    assign int_vc = polarity;
    assign ext_vc = ~polarity;

    // Fill and drain touch different slots, so they can share an edge.
    assign fill  = ~full_q[int_vc] & (|req);
    assign drain =  full_q[ext_vc] & ro;

    // A full internal slot blocks the grant and freezes the pointer.
    rr_grant_core #(.NREQ(NREQ)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .enable (~full_q[int_vc]),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        full_d     = full_q;
        slot_d     = slot_q;
        clear_d    = '0;
        so_d       = 1'b0;
        data_out_d = data_out_q;
        if (fill) begin
            slot_d[int_vc] = data_in[int'(winner)*DATA_W +: DATA_W];
            full_d[int_vc] = 1'b1;
            clear_d        = grant;
        end
        if (drain) begin
            so_d           = 1'b1;
            data_out_d     = slot_q[ext_vc];
            full_d[ext_vc] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q     <= '0;
            clear_q    <= '0;
            so_q       <= 1'b0;
            data_out_q <= '0;
        end else begin
            full_q     <= full_d;
            clear_q    <= clear_d;
            so_q       <= so_d;
            data_out_q <= data_out_d;
        end
    end

    // NOTE: slot storage has no reset; the full flags alone decide whether a
    // slot holds a valid flit, so clearing them discards the contents.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign clear    = clear_q;
    assign so       = so_q;
    assign data_out = data_out_q;
    assign empty    = ~full_q;

endmodule

// File: doc/output_port_scheduler.md
Name: output_port_scheduler

Overview:
Per-output-port scheduler for the mesh router. It arbitrates round-robin among the four input interfaces that target this output port, and buffers the winning flit in a two-slot, even/odd virtual-channel (VC) output buffer. It drives the send/ready handshake to the downstream router or NIC and returns a one-cycle clear pulse to the input buffer whose flit it accepted. The router instantiates one per output direction (E, W, N, S, PE).

Parameters:
DATA_W, 64, flit width in bits
NREQ, 4, number of requesting input interfaces

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
polarity  input  1  router polarity; toggles every cycle; selects the internal VC
req  input  NREQ  request vector; req[i]=1 means input i holds a flit for this port on VC = polarity
data_in  input  NREQ*DATA_W  flits from the inputs, packed; input i occupies [i*DATA_W +: DATA_W]
clear  output  NREQ  one-hot, one-cycle pulse to the granted input buffer
empty  output  2  per-VC slot-empty flags; bit v = slot v empty
ro  input  1  downstream ready for the external VC (= ~polarity) in this cycle
so  output  1  send-valid to downstream; one-cycle pulse per flit
data_out  output  DATA_W  flit to downstream; valid while so=1

Behaviour:
- Reset (reset=0 at a rising edge):
  - so=0, data_out=0, clear=0, empty=2'b11.
  - Round-robin pointer = NREQ-1, so input 0 has first priority.
  - Buffered flits are discarded.
  - Reset asserted mid-operation drops both slots; no clear or so pulse follows the reset edge.
- Two storage slots, buf[0] and buf[1], one per VC, each with a full flag; empty = ~full.
- In a cycle with polarity = p:
  - Slot p is the internal slot and may be filled.
  - Slot ~p is the external slot and may be drained.
  - Fill and drain are independent and may occur at the same edge.
- Fill:
  - Condition: ~full[p] and |req at the edge.
  - Winner = first requester at or after index (ptr+1) mod NREQ, searching upward with wrap-around.
  - At the edge: buf[p] <= winner's flit; full[p] <= 1; ptr <= winner; clear <= onehot(winner).
  - Otherwise clear <= 0.
  - clear is registered: it is high exactly in the cycle after capture and for one cycle only.
- Fill blocked: if full[p], no grant is made and clear stays 0. The pointer does not move, and requests must be held by the inputs.
- A single requester wins every time; the pointer still updates to its index.
- Drain:
  - Condition: full[~p] and ro at the edge.
  - At the edge: so <= 1; data_out <= buf[~p]; full[~p] <= 0.
  - Otherwise so <= 0 and data_out holds its last value.
- Latency: a flit captured at edge E0 (polarity p) is drained at the next edge E1 if ro=1 then. so is high in the cycle after E1, so minimum latency is 2 cycles from request to so.
- If ro=0, the flit waits in its slot. It is retried every second cycle, when its VC is again the external VC.
- A slot can be drained and then refilled on alternating cycles, giving a sustained throughput of 1 flit/cycle across the two VCs.
- Unknown/X on req while reset is low has no effect.
- empty is registered and reflects the full flags after each edge.

Decomposition:
- Shared package noc_pkg holds:
  - DATA_W and NREQ defaults.
  - VC_EVEN=0 and VC_ODD=1 constants.
  - Direction index constants: DIR_E, DIR_W, DIR_N, DIR_S, DIR_PE.
- One sub-module, rr_grant_core, holds the round-robin pointer register and the combinational rotate/priority search. Its interface:
  - Inputs: req, enable.
  - Outputs: one-hot grant, winner index.
  - The pointer updates only when enable is high and |req.
- The slot storage and handshake logic stay in output_port_scheduler.

Test Plan:
1. Reset check: reset=0 for 2 cycles → so=0, clear=0, empty=2'b11, data_out=0. Release reset, req=0, 10 cycles → no pulses.
2. Single flit: polarity=0, req=4'b0100 with data_in[2]=64'hA5A5_0000_0000_0001, ro=1 → clear=4'b0100 in the next cycle. Then so=1 with data_out=64'hA5A5_0000_0000_0001 two cycles after the request, and empty returns to 2'b11.
3. Round-robin fairness: req=4'b1111 held, ro=1, after reset → clear order 0,1,2,3,0,1… with one grant per cycle, alternating VC slots. There are no repeats before all four inputs are served.
4. Back-pressure: ro=0, req=4'b0001 → slot 0 fills, then slot 1 fills, empty=2'b00, and no further clear while req stays high. Then set ro=1 → so pulses on two consecutive cycles and clear resumes.
5. Wrap-around: ptr at 3 (last winner 3), req=4'b1001 → input 0 wins, then input 3 wins.
6. Mid-operation reset: both slots full, reset=0 for one edge → empty=2'b11 and so=0. No stale flit appears after reset is released, even with ro=1.
